// File: rtl/three_op_pkg.sv
// Shared definitions for the three-operand loader: op encodings, FSM states, default width.
package three_op_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_NEG_B = 2'b01;
    localparam logic [1:0] OP_NEG_A = 2'b10;
    localparam logic [1:0] OP_NEG_C = 2'b11;

    typedef enum logic [2:0] {
        HDR = 3'd0,
        LDA = 3'd1,
        LDB = 3'd2,
        LDC = 3'd3,
        EXE = 3'd4,
        OUT = 3'd5
    } state_e;

endpackage

// File: rtl/three_op_loader.sv
// Byte-stream sequencer feeding a combinational three-operand adder and returning its result.
// Optional header reserved-bit checking (hdr_err port) is enabled by THREE_OP_LOADER_HDR_CHECK_EN.
module three_op_loader
    import three_op_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic [WIDTH-1:0] add_c,
    output logic [1:0]       add_op,
    input  logic [WIDTH-1:0] add_r,
    input  logic             add_cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic [1:0]       res_op,
    output logic [CNT_W-1:0] ops_done
`ifdef THREE_OP_LOADER_HDR_CHECK_EN
    ,
    output logic             hdr_err
`endif
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic [WIDTH-1:0]   add_c_q, add_c_d;
    logic [1:0]         add_op_q, add_op_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_cout_q, res_cout_d;
    logic [1:0]         res_op_q, res_op_d;
    logic [CNT_W-1:0]   ops_done_q, ops_done_d;
    logic               xfer;

`ifdef THREE_OP_LOADER_HDR_CHECK_EN
    logic               hdr_err_q, hdr_err_d;
    logic               hdr_bad;

    assign hdr_bad = |in_data[WIDTH-1:2];
`endif

    assign in_ready = (state_q == HDR) || (state_q == LDA) ||
                      (state_q == LDB) || (state_q == LDC);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_c_d     = add_c_q;
        add_op_d    = add_op_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_cout_d  = res_cout_q;
        res_op_d    = res_op_q;
        ops_done_d  = ops_done_q;
`ifdef THREE_OP_LOADER_HDR_CHECK_EN
        hdr_err_d   = 1'b0;
`endif
        case (state_q)
            HDR: begin
                if (xfer) begin
`ifdef THREE_OP_LOADER_HDR_CHECK_EN
                    // A bad header is swallowed so the stream can resynchronise on the next byte.
                    if (hdr_bad) begin
                        hdr_err_d = 1'b1;
                    end else begin
                        add_op_d = in_data[1:0];
                        state_d  = LDA;
                    end
`else
                    add_op_d = in_data[1:0];
                    state_d  = LDA;
`endif
                end
            end
            LDA: begin
                if (xfer) begin
                    add_a_d = in_data;
                    state_d = LDB;
                end
            end
            LDB: begin
                if (xfer) begin
                    add_b_d = in_data;
                    state_d = LDC;
                end
            end
            LDC: begin
                if (xfer) begin
                    add_c_d = in_data;
                    state_d = EXE;
                end
            end
            EXE: begin
                // Operands have been stable for a full cycle, so the adder output is settled.
                res_data_d  = add_r;
                res_cout_d  = add_cout;
                res_op_d    = add_op_q;
                res_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + CNT_W'(1);
                    state_d     = HDR;
                end
            end
            default: begin
                state_d = HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_c_q     <= '0;
            add_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_op_q    <= '0;
            ops_done_q  <= '0;
`ifdef THREE_OP_LOADER_HDR_CHECK_EN
            hdr_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_c_q     <= add_c_d;
            add_op_q    <= add_op_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            res_op_q    <= res_op_d;
            ops_done_q  <= ops_done_d;
`ifdef THREE_OP_LOADER_HDR_CHECK_EN
            hdr_err_q   <= hdr_err_d;
`endif
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_c     = add_c_q;
    assign add_op    = add_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;
    assign res_op    = res_op_q;
    assign ops_done  = ops_done_q;
`ifdef THREE_OP_LOADER_HDR_CHECK_EN
    assign hdr_err   = hdr_err_q;
`endif

endmodule
